// File: rtl/regfile_init_bypass.sv
// Register file: two combinational read ports, one write port, post-reset clear sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_init_bypass #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
    localparam bit ZR = (ZERO_REG != 0);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_zero;

    // Writes aimed at the hardwired zero entry are discarded silently.
    assign wr_zero = ZR && (wr_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_drop <= wr_en;
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_PTR) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    wr_drop <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Storage has no reset so it can map onto RAM; the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr[ADDR_W-1:0]] <= '0;
        end else if (wr_en && !wr_zero) begin
            mem[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (state != RUN) begin
            r = '0;
        end else if (BYP && wr_en && !wr_zero && (wr_addr == a)) begin
            r = wr_data;
        end else if (ZR && (a == '0)) begin
            r = '0;
        end else begin
            r = mem[a];
        end
        return r;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

endmodule
